// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register offsets inside the 8-byte window, STATUS bit positions
// and the parity helper used by the optional parity build.
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_ACTIVE  = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_PARITY  = 8;

    // Even parity bit: XOR of all data bits, independent of bit order.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered storage and combinational read of the
// head entry. The caller guarantees push only when not full (or together
// with a pop) and pop only when not empty. Pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = push ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO state registers with synchronous reset (flush).
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: {WIDTH{1'b0}}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a TX FIFO.
// Register window: +0 TXDATA (write pushes a byte), +4 STATUS.
// Build option MMIO_UART_TX_PARITY_EN adds an even-parity bit after the data
// bits and sets STATUS[8].
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic        tx,
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic          tx_q, tx_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;

    logic          wr_data_s, wr_stat_s, push_s, pop_s, baud_done_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_rdata_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0]   cnt_ext_s, status_s;
    logic          unused_ok_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (writedata[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Address decode, push/overflow control and the STATUS read word.
    always_comb begin
        io_sel    = (addr[31:3] == BASE_ADDR[31:3]);
        wr_data_s = memwrite & io_sel & (addr[2] == TXDATA_OFS[2]);
        wr_stat_s = memwrite & io_sel & (addr[2] == STATUS_OFS[2]);
        // A full FIFO still accepts a byte when the FSM frees a slot this cycle.
        push_s    = wr_data_s & (~fifo_full_s | pop_s);
        // Set has priority over a clear in the same cycle.
        if (wr_data_s & fifo_full_s & ~pop_s) begin
            ovf_d = 1'b1;
        end else if (wr_stat_s & writedata[STAT_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        cnt_ext_s = 32'(fifo_count_s);
        status_s  = 32'd0;
        status_s[STAT_FULL]   = fifo_full_s;
        status_s[STAT_EMPTY]  = fifo_empty_s;
        status_s[STAT_ACTIVE] = (state_q != ST_IDLE);
        status_s[STAT_OVF]    = ovf_q;
        status_s[STAT_CNT_LSB +: 4] = (cnt_ext_s > 32'd15) ? 4'hF : cnt_ext_s[3:0];
`ifdef MMIO_UART_TX_PARITY_EN
        status_s[STAT_PARITY] = 1'b1;
`else
        status_s[STAT_PARITY] = 1'b0;
`endif
        io_rdata    = (io_sel && (addr[2] == STATUS_OFS[2])) ? status_s : 32'd0;
        unused_ok_s = ^{writedata[31:8], addr[1:0]};
    end

    // Transmit FSM next-state: framing, baud count-down and FIFO pop.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pop_s       = 1'b0;
        baud_done_s = (baud_q == {BW{1'b0}});
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q - BW'(1'b1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = even_parity(shift_q);
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Rotate so the byte stays intact for the parity XOR.
                        shift_d = {shift_q[0], shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - BW'(1'b1);
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d  = baud_q - BW'(1'b1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_done_s) begin
                    if (!fifo_empty_s) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // FSM, serial output and overflow flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = ~fifo_empty_s | (state_q != ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A queue-level model decides at each clock edge which byte starts a frame
// and when; a separate monitor decodes the tx line and checks each frame.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic        io_sel, tx, busy;
    logic [31:0] io_rdata;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .io_sel(io_sel), .io_rdata(io_rdata),
        .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0;
    int         cyc = 0, active_until = 0, last_pop = 0;
    int         pops_total = 0, frames_seen = 0;
    bit         ovf = 1'b0, abort_req = 1'b0, mon_en = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         exp_start[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int n;
        n = mq.size();
        s = 32'd0;
        s[0]   = (n == DEPTH);
        s[1]   = (n == 0);
        s[2]   = (active_until > cyc);
        s[3]   = ovf;
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        s[8]   = PAR;
        return s;
    endfunction

    function automatic logic model_busy();
        return (mq.size() > 0) || (active_until > cyc);
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Reference model: one step per rising edge, from queue rules only.
    task automatic model_step();
        logic sel;
        if (reset) begin
            mq.delete(); exp_q.delete(); exp_start.delete();
            active_until = 0; ovf = 1'b0; abort_req = 1'b1;
        end else begin
            if (mq.size() > 0 && cyc >= active_until) begin
                exp_q.push_back(mq.pop_front());
                exp_start.push_back(cyc);
                active_until = cyc + FRAME;
                last_pop = cyc;
                pops_total++;
            end
            sel = (addr[31:3] == BASE[31:3]);
            if (memwrite && sel) begin
                if (!addr[2]) begin
                    if (mq.size() < DEPTH) mq.push_back(writedata[7:0]);
                    else ovf = 1'b1;
                end else if (writedata[3]) begin
                    ovf = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Monitor: decode every frame on tx and compare against the scoreboard.
    initial begin
        logic [7:0] b;
        int st, errs;
        bit aborted;
        forever begin
            @(negedge clk);
            abort_req = 1'b0;
            if (mon_en && tx === 1'b0) begin
                frames_seen++;
                chk("frame_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    st = exp_start.pop_front();
                    chk("frame_start_cycle", cyc, st);
                    errs = 0;
                    aborted = 1'b0;
                    for (int i = 0; i < FRAME; i++) begin
                        if (i > 0) begin
                            @(negedge clk);
                            if (abort_req) begin
                                aborted = 1'b1;
                                abort_req = 1'b0;
                                break;
                            end
                        end
                        if (tx !== frame_bit(b, i / CPB)) errs++;
                    end
                    if (!aborted) chk($sformatf("frame_bits_%02h", b), errs, 0);
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite = 1'b1; addr = a; writedata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            memwrite = 1'b0;
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] a);
        logic [31:0] exp;
        @(negedge clk);
        memwrite = 1'b0; addr = a;
        #1;
        exp = (a[31:3] == BASE[31:3] && a[2]) ? model_status() : 32'd0;
        chk({name, "_sel"}, io_sel, (a[31:3] == BASE[31:3]));
        chk({name, "_rdata"}, io_rdata, exp);
        chk({name, "_busy"}, busy, model_busy());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (model_busy() && n < 3000) begin
            idle(1);
            n++;
        end
        idle(2);
        #1;
        chk({name, "_busy"}, busy, model_busy());
        chk({name, "_tx"}, tx, 32'd1);
    endtask

    initial begin
        int lows, n, r;
        // Reset
        idle(2);
        reset = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("reset_tx", tx, 32'd1);
        chk("reset_busy", busy, 32'd0);
        read_chk("status_after_reset", BASE + 32'd4);
        read_chk("load_outside", 32'h0000_0010);
        read_chk("load_next_window", BASE + 32'd8);
        read_chk("txdata_alias", BASE + 32'd3);
        read_chk("status_alias", BASE + 32'd7);

        // Single byte 0x55 and busy-fall timing
        store(BASE, 32'h0000_0055);
        idle(1);
        n = 0;
        while (cyc < last_pop + FRAME - 1 && n < 200) begin idle(1); n++; end
        #1;
        chk("busy_last_frame_cycle", busy, 32'd1);
        idle(1);
        #1;
        chk("busy_after_frame", busy, 32'd0);
        drain("single");

        // Ten consecutive stores: one popped, eight buffered, one dropped
        for (int i = 0; i < 10; i++) store(BASE, $urandom & 32'hFF);
        read_chk("status_overflow", BASE + 32'd4);
        store(BASE + 32'd4, 32'h0000_0008);
        read_chk("status_ovf_cleared", BASE + 32'd4);
        drain("burst");

        // Back-to-back frames
        store(BASE, 32'h0000_00A5);
        store(BASE, 32'h0000_003C);
        store(BASE, 32'h0000_0007);
        drain("b2b");

        // Reset during data bit 3 with bytes still queued
        store(BASE, 32'h0000_00C3);
        store(BASE, 32'h0000_0011);
        store(BASE, 32'h0000_0022);
        n = 0;
        while (cyc < last_pop + 16 && n < 200) begin idle(1); n++; end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        #1;
        chk("midreset_tx", tx, 32'd1);
        chk("midreset_busy", busy, 32'd0);
        read_chk("midreset_status", BASE + 32'd4);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (tx !== 1'b1) lows++;
        end
        chk("midreset_no_frames", lows, 0);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      store(BASE | ($urandom & 32'h3), $urandom);
            else if (r == 5) store(BASE + 32'd4, $urandom);
            else if (r == 6) store($urandom & 32'h7FFF_FFF8, $urandom);
            else if (r == 7) read_chk("rand_status", BASE + 32'd4);
            else             idle($urandom_range(1, 30));
        end
        read_chk("rand_final_status", BASE + 32'd4);
        drain("random");

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frames_seen", frames_seen, pops_total);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
